timer_ctrl: RTL and testbench

- Memory-mapped machine-timer controller; owns the 64-bit mtime counter and mtimecmp register and generates the machine timer interrupt.
- Attaches to the mmu as one read/write device, mapped 0xa000_0010–0xa000_0027.
- Exports mtime and timer_irq to the cpu.
- Adds a programmable prescaler, enable control, atomic high-word read snapshot and a sticky overflow flag.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_prescaler.sv | 28 ++
 rtl/timer_ctrl.sv | 124 ++++++++++++
 tb/tb_timer_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register map,
// ctrl/status bit positions and the default compare reset value.
package timer_pkg;

  typedef enum logic [2:0] {
    MTIME_LO    = 3'd0,
    MTIME_HI    = 3'd1,
    MTIMECMP_LO = 3'd2,
    MTIMECMP_HI = 3'd3,
    CTRL        = 3'd4,
    STATUS      = 3'd5
  } timer_reg_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_DIV_LSB    = 8;
  localparam int STATUS_IRQ_BIT  = 0;
  localparam int STATUS_OVF_BIT  = 1;

  localparam logic [63:0] CMP_RESET_DFLT = 64'hffff_ffff_ffff_ffff;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock prescaler: one-cycle tick every div+1 enabled clocks.
// The count holds while disabled; clear restarts the count from zero.
module timer_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 clear,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = enable && (cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Machine-timer controller: 64-bit mtime/mtimecmp with prescaler, enable,
// high-word read snapshot, sticky overflow and a registered level interrupt.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int          DIV_WIDTH    = 8,
  parameter logic [63:0] CMP_RESET    = CMP_RESET_DFLT,
  parameter logic        ENABLE_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        re,
  output logic [31:0] rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [63:0] mtime,
  output logic        timer_irq
);

  timer_reg_e           reg_sel;
  logic [63:0]          mtimecmp;
  logic [63:0]          mtime_next;
  logic [63:0]          mtimecmp_next;
  logic [31:0]          hi_shadow;
  logic                 enable;
  logic [DIV_WIDTH-1:0] div;
  logic                 ovf;
  logic                 ovf_next;
  logic                 tick;
  logic                 wrap;
  logic                 wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
  logic                 unused_addr;

  assign reg_sel     = timer_reg_e'(addr[2:0]);
  assign unused_addr = ^addr[29:3];

  assign wr_lo     = we && (reg_sel == MTIME_LO);
  assign wr_hi     = we && (reg_sel == MTIME_HI);
  assign wr_cmp_lo = we && (reg_sel == MTIMECMP_LO);
  assign wr_cmp_hi = we && (reg_sel == MTIMECMP_HI);
  assign wr_ctrl   = we && (reg_sel == CTRL);
  assign wr_status = we && (reg_sel == STATUS);

  timer_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .div    (div),
    .clear  (wr_ctrl),
    .tick   (tick)
  );

  // A software write to either mtime half swallows the tick of that cycle.
  always_comb begin
    mtime_next = mtime;
    wrap       = 1'b0;
    if (wr_lo) begin
      mtime_next = {mtime[63:32], wd};
    end else if (wr_hi) begin
      mtime_next = {wd, mtime[31:0]};
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
      wrap       = &mtime;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (wr_cmp_lo) mtimecmp_next[31:0]  = wd;
    if (wr_cmp_hi) mtimecmp_next[63:32] = wd;
  end

  // Wrap beats a same-cycle write-1-to-clear.
  always_comb begin
    ovf_next = ovf;
    if (wr_status && wd[STATUS_OVF_BIT]) ovf_next = 1'b0;
    if (wrap) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= CMP_RESET;
      hi_shadow <= '0;
      enable    <= ENABLE_RESET;
      div       <= '0;
      ovf       <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_next;
      mtimecmp  <= mtimecmp_next;
      ovf       <= ovf_next;
      timer_irq <= (mtime_next >= mtimecmp_next);
      if (re && (reg_sel == MTIME_LO)) hi_shadow <= mtime[63:32];
      if (wr_ctrl) begin
        enable <= wd[CTRL_EN_BIT];
        div    <= wd[CTRL_DIV_LSB +: DIV_WIDTH];
      end
    end
  end

  always_comb begin
    rd = '0;
    if (re) begin
      case (reg_sel)
        MTIME_LO:    rd = mtime[31:0];
        MTIME_HI:    rd = hi_shadow;
        MTIMECMP_LO: rd = mtimecmp[31:0];
        MTIMECMP_HI: rd = mtimecmp[63:32];
        CTRL: begin
          rd[CTRL_EN_BIT]                 = enable;
          rd[CTRL_DIV_LSB +: DIV_WIDTH]   = div;
        end
        STATUS: begin
          rd[STATUS_IRQ_BIT] = timer_irq;
          rd[STATUS_OVF_BIT] = ovf;
        end
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed register table, corner-case
// sequences and a randomized run against a behavioural reference model.
module tb_timer_ctrl;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        re;
  logic [31:0] rd;
  logic        we;
  logic [31:0] wd;
  logic [63:0] mtime;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  timer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .re        (re),
    .rd        (rd),
    .we        (we),
    .wd        (wd),
    .mtime     (mtime),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_shadow;
  logic        m_en, m_ovf, m_irq;
  logic [7:0]  m_div;
  int          m_pc;
  logic [31:0] last_rd;

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time = 64'd0; m_cmp = 64'hffff_ffff_ffff_ffff; m_shadow = 32'd0;
    m_en = 1'b1; m_div = 8'd0; m_pc = 0; m_ovf = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_time[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {16'd0, m_div, 7'd0, m_en};
      3'd5: return {30'd0, m_ovf, m_irq};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    logic tick, wrap;
    tick = m_en && (m_pc == int'(m_div));
    wrap = 1'b0;
    if (r && a == 3'd0) m_shadow = m_time[63:32];
    if (w && a == 3'd0)      m_time[31:0]  = d;
    else if (w && a == 3'd1) m_time[63:32] = d;
    else if (tick) begin
      wrap   = (m_time == 64'hffff_ffff_ffff_ffff);
      m_time = m_time + 64'd1;
    end
    if (w && a == 3'd2) m_cmp[31:0]  = d;
    if (w && a == 3'd3) m_cmp[63:32] = d;
    if (w && a == 3'd5 && d[1]) m_ovf = 1'b0;
    if (wrap) m_ovf = 1'b1;
    if (w && a == 3'd4) begin
      m_en  = d[0];
      m_div = d[15:8];
      m_pc  = 0;
    end else if (m_en) begin
      m_pc = (m_pc + 1) % (int'(m_div) + 1);
    end
    m_irq = (m_time >= m_cmp);
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic cycle(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    we = w; re = r; wd = d;
    addr = {27'($urandom), a};
    @(negedge clk);
    if (r) chk("rd", {32'd0, rd}, {32'd0, model_rd(a)});
    else   chk("rd_idle", {32'd0, rd}, 64'd0);
    last_rd = rd;
    model_step(w, r, a, d);
    @(posedge clk); #1;
    chk("mtime", mtime, m_time);
    chk("irq", {63'd0, timer_irq}, {63'd0, m_irq});
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    logic [63:0] base;
    logic [2:0]  ra;
    logic [31:0] rdat;
    logic        rw, rr;
    int          sel;

    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wd = '0;
    model_reset();
    #1;
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_irq", {63'd0, timer_irq}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: free-running at div=0
    idle(20);
    chk("t1_mtime20", mtime, 64'd20);

    vecs.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_0001});
    vecs.push_back('{1'b0, 3'd5, 32'h0,          32'h0000_0000});
    vecs.push_back('{1'b0, 3'd2, 32'h0,          32'hffff_ffff});
    vecs.push_back('{1'b0, 3'd3, 32'h0,          32'hffff_ffff});
    vecs.push_back('{1'b0, 3'd6, 32'h0,          32'h0000_0000});
    vecs.push_back('{1'b0, 3'd7, 32'h0,          32'h0000_0000});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_1234,  32'h0000_0000});
    vecs.push_back('{1'b0, 3'd6, 32'h0,          32'h0000_0000});
    vecs.push_back('{1'b0, 3'd1, 32'h0,          32'h0000_0000});
    vecs.push_back('{1'b1, 3'd4, 32'hdead_ff01,  32'h0000_0001});
    vecs.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_ff01});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0001,  32'h0000_ff01});
    vecs.push_back('{1'b0, 3'd4, 32'h0,          32'h0000_0001});
    foreach (vecs[i]) begin
      cycle(vecs[i].w, 1'b1, vecs[i].a, vecs[i].d);
      chk($sformatf("tbl%0d", i), {32'd0, last_rd}, {32'd0, vecs[i].exp});
    end

    // 2: div=3 gives 3 ticks in 12 clocks; disable freezes
    cycle(1'b1, 1'b0, 3'd4, 32'h0000_0301);
    base = m_time;
    idle(12);
    chk("t2_div3", mtime, base + 64'd3);
    cycle(1'b1, 1'b0, 3'd4, 32'h0);
    base = m_time;
    idle(50);
    chk("t2_frozen", mtime, base);

    // 3: compare crossing
    cycle(1'b1, 1'b0, 3'd4, 32'h1);
    cycle(1'b1, 1'b0, 3'd3, 32'd0);
    cycle(1'b1, 1'b0, 3'd2, 32'd100);
    cycle(1'b1, 1'b0, 3'd1, 32'd0);
    cycle(1'b1, 1'b0, 3'd0, 32'd90);
    chk("t3_mtime90", mtime, 64'd90);
    idle(9);
    chk("t3_irq_at99", {63'd0, timer_irq}, 64'd0);
    idle(1);
    chk("t3_mtime100", mtime, 64'd100);
    chk("t3_irq_at100", {63'd0, timer_irq}, 64'd1);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    chk("t3_status", {32'd0, last_rd}, 64'h1);
    cycle(1'b1, 1'b0, 3'd2, 32'hffff_ffff);
    chk("t3_irq_drop", {63'd0, timer_irq}, 64'd0);

    // 4: wrap sets ovf, W1C clears, wrap beats clear
    cycle(1'b1, 1'b0, 3'd1, 32'hffff_ffff);
    cycle(1'b1, 1'b0, 3'd0, 32'hffff_fffe);
    idle(2);
    chk("t4_wrap0", mtime, 64'd0);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    chk("t4_ovf_set", {32'd0, last_rd}, 64'h2);
    cycle(1'b1, 1'b0, 3'd5, 32'h2);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    chk("t4_ovf_clr", {32'd0, last_rd}, 64'h0);
    cycle(1'b1, 1'b0, 3'd1, 32'hffff_ffff);
    cycle(1'b1, 1'b0, 3'd0, 32'hffff_ffff);
    cycle(1'b1, 1'b0, 3'd5, 32'h2);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    chk("t4_set_wins", {32'd0, last_rd}, 64'h2);

    // 5: hi read returns the snapshot taken at the lo read
    cycle(1'b1, 1'b0, 3'd1, 32'h1);
    cycle(1'b1, 1'b0, 3'd0, 32'hffff_fffe);
    idle(1);
    cycle(1'b0, 1'b1, 3'd0, 32'd0);
    chk("t5_lo", {32'd0, last_rd}, 64'hffff_ffff);
    cycle(1'b0, 1'b1, 3'd1, 32'd0);
    chk("t5_hi_snap", {32'd0, last_rd}, 64'h1);
    chk("t5_hi_now", {32'd0, mtime[63:32]}, 64'd2);

    // 6: asynchronous reset mid-count
    cycle(1'b1, 1'b0, 3'd4, 32'h0000_0201);
    cycle(1'b1, 1'b0, 3'd1, 32'd0);
    cycle(1'b1, 1'b0, 3'd0, 32'd500);
    chk("t6_mtime500", mtime, 64'd500);
    idle(4);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_mtime", mtime, 64'd0);
    chk("t6_rst_irq", {63'd0, timer_irq}, 64'd0);
    re = 1'b1;
    addr = 30'd5; #1 chk("t6_status", {32'd0, rd}, 64'h0);
    addr = 30'd2; #1 chk("t6_cmp_lo", {32'd0, rd}, 64'hffff_ffff);
    addr = 30'd3; #1 chk("t6_cmp_hi", {32'd0, rd}, 64'hffff_ffff);
    addr = 30'd4; #1 chk("t6_ctrl", {32'd0, rd}, 64'h1);
    addr = 30'd6; #1 chk("t6_addr6", {32'd0, rd}, 64'h0);
    re = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);
    chk("t6_restart", mtime, 64'd5);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      ra = 3'($urandom_range(0, 7));
      rw = ($urandom_range(0, 3) == 0);
      rr = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      case (ra)
        3'd0, 3'd1, 3'd2, 3'd3:
          rdat = (sel == 0) ? 32'hffff_ffff :
                 (sel == 1) ? 32'hffff_fffe :
                 (sel == 2) ? 32'($urandom_range(0, 50)) : $urandom;
        3'd4: rdat = ($urandom & 32'hffff_0300) | {31'd0, ($urandom_range(0, 3) != 0)};
        default: rdat = $urandom;
      endcase
      cycle(rw, rr, ra, rdat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
